// File: rtl/sync_fifo_stream_rd_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
package sync_fifo_stream_rd_pkg;

    // Output buffer occupancy, doubles as the buffer FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    // Read latency of the counter-based FIFO (dout registered after rd_en).
    localparam int RD_LAT = 1;

endpackage

// File: rtl/sync_fifo_stream_rd_if.sv
// FIFO read port plus valid/ready stream, grouped for the adapter.
interface sync_fifo_stream_rd_if #(
    parameter int WIDTH = 8
);
    logic             fifo_rd_en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    // Adapter side: drives the FIFO read request and the stream.
    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_dout,
        output m_valid,
        input  m_ready,
        output m_data
    );

    // Environment side: FIFO plus stream consumer.
    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_dout,
        input  m_valid,
        output m_ready,
        input  m_data
    );
endinterface

// File: rtl/sync_fifo_stream_rd_stream_skid2.sv
// Two-entry output buffer: buf0 is the head presented downstream,
// buf1 holds a word captured while the head is stalled.
module stream_skid2
    import sync_fifo_stream_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output occ_t             occ
);
    logic [WIDTH-1:0] buf0;
    logic [WIDTH-1:0] buf1;

    // Occupancy FSM; a push lands in the first slot free after this cycle's pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= EMPTY;
            buf0 <= '0;
            buf1 <= '0;
        end else if (flush) begin
            occ <= EMPTY;
        end else begin
            case (occ)
                EMPTY: begin
                    if (push) begin
                        occ  <= ONE;
                        buf0 <= push_data;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        occ  <= TWO;
                        buf1 <= push_data;
                    end else if (push && pop) begin
                        buf0 <= push_data;
                    end else if (pop) begin
                        occ <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        buf0 <= buf1;
                        if (push) buf1 <= push_data;
                        else      occ  <= ONE;
                    end
                end
                default: occ <= EMPTY;
            endcase
        end
    end

    assign head = buf0;

    // The upstream credit rule must never deliver a word into a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(occ == TWO && push && !pop && !flush));

endmodule

// File: rtl/sync_fifo_stream_rd.sv
// Read-side adapter: drains a 1-cycle-latency FIFO and re-presents the data
// as a full-throughput valid/ready stream.
module sync_fifo_stream_rd
    import sync_fifo_stream_rd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_fifo_stream_rd_if.master bus,
    input  logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt
);
    logic             inflight;
    logic             pop;
    logic             rd_en;
    logic             valid;
    logic             cap;
    logic [2:0]       credit;
    logic [WIDTH-1:0] head;
    occ_t             occ;

    assign valid = (occ != EMPTY);
    assign pop   = valid && bus.m_ready;
    assign cap   = inflight && !flush;

    // Slots committed after this cycle: buffered + returning word - leaving word.
    assign credit = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign rd_en  = rst_n && !flush && !bus.fifo_empty && (credit < 3'd2);

    // Track the read whose data returns next cycle; flush blocks rd_en, so it
    // also clears the in-flight marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight <= 1'b0;
        else        inflight <= rd_en;
    end

    // Completed-handshake counter, wraps naturally; flush-cycle pops still count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   beat_cnt <= '0;
        else if (pop) beat_cnt <= beat_cnt + 1'b1;
    end

    stream_skid2 #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cap),
        .push_data (bus.fifo_dout),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .occ       (occ)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid;
    assign bus.m_data     = head;
    assign busy           = valid || inflight;

endmodule

// File: tb/tb_sync_fifo_stream_rd.sv
// Bench for sync_fifo_stream_rd: FIFO model, stream consumer, scoreboard.
module tb_sync_fifo_stream_rd;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             busy;
    logic [CNT_W-1:0] beat_cnt;

    sync_fifo_stream_rd_if #(.WIDTH(WIDTH)) bus();

    sync_fifo_stream_rd #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .flush    (flush),
        .busy     (busy),
        .beat_cnt (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] fq[$];     // words still held by the FIFO
    logic [WIDTH-1:0] exp_q[$];  // words expected on the stream, in order
    int               outstanding = 0; // read from FIFO, not yet delivered
    int               prev_rd     = 0;
    int               prev_stall  = 0;
    logic [WIDTH-1:0] prev_data   = '0;
    logic [CNT_W-1:0] model_cnt   = '0;
    int               rd_window   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO with registered read data.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.fifo_dout <= '0;
        else if (bus.fifo_rd_en && fq.size() > 0) bus.fifo_dout <= fq.pop_front();
    end

    // Monitor: checks the state visible this cycle, then books what the next edge does.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", {31'b0, busy}, {31'b0, outstanding != 0});
            chk("m_valid", {31'b0, bus.m_valid}, {31'b0, (outstanding - prev_rd) != 0});
            chk("beat_cnt", {28'b0, beat_cnt}, {28'b0, model_cnt});
            chk("credit_bound", {31'b0, outstanding <= 2}, 32'd1);
            if (bus.fifo_rd_en) chk("rd_while_empty", {31'b0, bus.fifo_empty}, 32'd0);
            if (prev_stall != 0) begin
                chk("hold_valid", {31'b0, bus.m_valid}, 32'd1);
                chk("hold_data", {24'b0, bus.m_data}, {24'b0, prev_data});
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat actual=%0h required=none at %0t", bus.m_data, $time);
                end else begin
                    chk("data", {24'b0, bus.m_data}, {24'b0, exp_q.pop_front()});
                end
                model_cnt = model_cnt + 1'b1;
                outstanding--;
            end
            if (bus.fifo_rd_en) begin
                outstanding++;
                rd_window++;
            end
            if (flush) begin
                // Everything already taken from the FIFO but not delivered is gone.
                repeat (outstanding) if (exp_q.size() > 0) void'(exp_q.pop_front());
                outstanding = 0;
            end
            prev_rd    = bus.fifo_rd_en ? 1 : 0;
            prev_stall = (bus.m_valid && !bus.m_ready && !flush) ? 1 : 0;
            prev_data  = bus.m_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.fifo_empty = (fq.size() == 0);
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit toggle);
        int i;
        for (i = 0; i < budget; i++) begin
            if (fq.size() == 0 && exp_q.size() == 0 && !busy) break;
            if (toggle) bus.m_ready = ~bus.m_ready;
            step();
        end
        chk("idle_within_budget", {31'b0, i < budget}, 32'd1);
    endtask

    task automatic clear_model();
        fq.delete();
        exp_q.delete();
        outstanding = 0;
        prev_rd     = 0;
        prev_stall  = 0;
        model_cnt   = '0;
    endtask

    initial begin
        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.m_ready    = 1'b0;
        bus.fifo_empty = 1'b1;
        #1;
        chk("rst_m_valid", {31'b0, bus.m_valid}, 32'd0);
        chk("rst_m_data", {24'b0, bus.m_data}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_beat_cnt", {28'b0, beat_cnt}, 32'd0);

        // Preload three words, stream them with the consumer always ready.
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        chk("rst_rd_en_forced", {31'b0, bus.fifo_rd_en}, 32'd0);
        bus.m_ready = 1'b1;
        step();
        rst_n = 1'b1;
        @(negedge clk); chk("t1_rd_c0", {31'b0, bus.fifo_rd_en}, 32'd1);
        step();
        @(negedge clk); chk("t1_rd_c1", {31'b0, bus.fifo_rd_en}, 32'd1);
        step();
        @(negedge clk);
        chk("t1_rd_c2", {31'b0, bus.fifo_rd_en}, 32'd1);
        chk("t1_valid_c2", {31'b0, bus.m_valid}, 32'd1);
        chk("t1_data_c2", {24'b0, bus.m_data}, 32'h11);
        step();
        wait_idle(20, 1'b0);
        chk("t1_beat_cnt", {28'b0, beat_cnt}, 32'd3);
        chk("t1_busy", {31'b0, busy}, 32'd0);

        // Stalled consumer: only two reads, head held, then full drain.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
        rd_window = 0;
        repeat (10) step();
        chk("t2_reads_stalled", rd_window, 32'd2);
        chk("t2_head", {24'b0, bus.m_data}, 32'hA0);
        bus.m_ready = 1'b1;
        wait_idle(30, 1'b0);

        // Consumer ready alternating every cycle.
        for (int i = 0; i < 16; i++) push_word(8'(i));
        wait_idle(100, 1'b1);
        bus.m_ready = 1'b1;

        // Empty FIFO, then a single word: exact first-beat latency.
        repeat (5) begin
            step();
            chk("t4_no_rd_empty", {31'b0, bus.fifo_rd_en}, 32'd0);
        end
        push_word(8'h5A);
        @(negedge clk);
        chk("t4_rd_n", {31'b0, bus.fifo_rd_en}, 32'd1);
        chk("t4_valid_n", {31'b0, bus.m_valid}, 32'd0);
        step();
        @(negedge clk); chk("t4_valid_n1", {31'b0, bus.m_valid}, 32'd0);
        step();
        @(negedge clk);
        chk("t4_valid_n2", {31'b0, bus.m_valid}, 32'd1);
        chk("t4_data_n2", {24'b0, bus.m_data}, 32'h5A);
        step();
        wait_idle(20, 1'b0);

        // Flush with a full buffer, then resume.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(8'hC0 + 8'(i));
        repeat (6) step();
        flush = 1'b1;
        @(negedge clk);
        chk("t5_flush_rd", {31'b0, bus.fifo_rd_en}, 32'd0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("t5_valid_after", {31'b0, bus.m_valid}, 32'd0);
        chk("t5_busy_after", {31'b0, busy}, 32'd0);
        bus.m_ready = 1'b1;
        step();
        wait_idle(30, 1'b0);

        // Flush in the middle of a full-rate stream.
        for (int i = 0; i < 8; i++) push_word(8'hD0 + 8'(i));
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_idle(30, 1'b0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 10; i++) push_word(8'hE0 + 8'(i));
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'b0, bus.m_valid}, 32'd0);
        chk("t6_rst_cnt", {28'b0, beat_cnt}, 32'd0);
        chk("t6_rst_busy", {31'b0, busy}, 32'd0);
        clear_model();
        bus.fifo_empty = 1'b1;
        step();
        rst_n = 1'b1;

        // 17 beats through a 4-bit counter.
        for (int i = 0; i < 17; i++) push_word(8'(8'h40 + i));
        wait_idle(60, 1'b0);
        chk("t6_cnt_wrap", {28'b0, beat_cnt}, 32'd1);

        // Random traffic, backpressure and occasional flushes.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) != 0) push_word(8'($urandom));
            bus.m_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            step();
            flush = 1'b0;
        end
        bus.m_ready = 1'b1;
        wait_idle(1000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
